// File: rtl/cpu_ctrl_pkg.sv
// Shared state encoding for the CPU step/run sequencer.
package cpu_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_HALT  = 3'd0,
    ST_STEP  = 3'd1,
    ST_RUN   = 3'd2,
    ST_BREAK = 3'd3
  } ctrl_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// registered one-cycle pulse on each debounced rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      cnt        <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync1      <= raw;
      sync2      <= sync1;
      rise_pulse <= 1'b0;
      // Any sample that agrees with the current level restarts the stability window.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt        <= '0;
        level      <= sync2;
        rise_pulse <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Clock-enable sequencer for the single-cycle CPU: free-run, single-step from
// a button, and stop on a PC breakpoint or halt instruction.
module cpu_step_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_DIV         = 50000000,
  parameter int CNT_W           = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               btn_step,
  input  logic               sw_run,
  input  logic               sw_bp_en,
  input  logic [31:0]        bp_addr,
  input  logic [31:0]        cur_pc,
  input  logic               halt_insn,
  output logic               cpu_en,
  output logic [STATE_W-1:0] state_o,
  output logic [CNT_W-1:0]   step_count,
  output logic               brk_hit
);

  localparam int DIV_W = $clog2(RUN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  ctrl_state_e      state;
  logic [DIV_W-1:0] div;
  logic             skip_bp;
  logic             run_s1;
  logic             run_s;
  logic             db_level;
  logic             db_rise;
  logic             step_req;
  logic             stop_now;
  logic [CNT_W-1:0] cnt_inc;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_db (
    .CLK       (CLK),
    .RST       (RST),
    .raw       (btn_step),
    .level     (db_level),
    .rise_pulse(db_rise)
  );

  // A rise pulse is only meaningful while the debounced level is actually high.
  assign step_req = db_rise & db_level;

  // skip_bp lets the first pulse after (re)entering RUN execute the instruction sitting on the breakpoint.
  assign stop_now = halt_insn | (sw_bp_en & ~skip_bp & (cur_pc == bp_addr));
  assign cnt_inc  = (step_count == {CNT_W{1'b1}}) ? step_count : step_count + 1'b1;
  assign state_o  = state;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      run_s1 <= 1'b0;
      run_s  <= 1'b0;
    end else begin
      run_s1 <= sw_run;
      run_s  <= run_s1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= ST_HALT;
      cpu_en     <= 1'b0;
      step_count <= '0;
      brk_hit    <= 1'b0;
      div        <= '0;
      skip_bp    <= 1'b0;
    end else begin
      cpu_en  <= 1'b0;
      brk_hit <= 1'b0;
      unique case (state)
        ST_HALT: begin
          if (run_s) begin
            state   <= ST_RUN;
            div     <= '0;
            skip_bp <= 1'b1;
          end else if (step_req) begin
            state <= ST_STEP;
          end
        end
        ST_STEP: begin
          if (halt_insn) begin
            state   <= ST_BREAK;
            brk_hit <= 1'b1;
          end else begin
            cpu_en     <= 1'b1;
            step_count <= cnt_inc;
            state      <= ST_HALT;
          end
        end
        ST_RUN: begin
          // Dropping the run switch wins over a pulse due on the same edge.
          if (!run_s) begin
            state <= ST_HALT;
            div   <= '0;
          end else if (div == DIV_LAST) begin
            div <= '0;
            if (stop_now) begin
              state   <= ST_BREAK;
              brk_hit <= 1'b1;
            end else begin
              cpu_en     <= 1'b1;
              step_count <= cnt_inc;
              skip_bp    <= 1'b0;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        ST_BREAK: begin
          if (!run_s) begin
            state <= ST_HALT;
          end else if (step_req) begin
            state <= ST_STEP;
          end else begin
            brk_hit <= 1'b1;
          end
        end
        default: state <= ST_HALT;
      endcase
    end
  end

endmodule
